// File: rtl/bpu_btb.sv
// Branch prediction unit: direct-mapped BTB plus a PHT of saturating counters.
// Supports static, bimodal and gshare prediction, with branch/mispredict counters.
module bpu_btb #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int MODE    = 1,
  parameter int GHR_W   = $clog2(ENTRIES)
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_vld,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_br,
  input  logic        i_upd_is_jmp,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_mispred,
  input  logic        i_flush_tbl,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] PHT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic             r_vld [ENTRIES];
  logic [TAG_W-1:0] r_tag [ENTRIES];
  logic [31:0]      r_tgt [ENTRIES];
  logic             r_jmp [ENTRIES];
  logic [CNT_W-1:0] r_pht [ENTRIES];
  logic [GHR_W-1:0] r_ghr;
  logic [31:0]      r_br_cnt;
  logic [31:0]      r_mis_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_lk_pidx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_hit;
  logic             w_dir;
  logic [IDX_W-1:0] w_up_idx;
  logic [IDX_W-1:0] w_up_pidx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_upd_eff;
  logic [CNT_W-1:0] w_pht_cur;
  logic [CNT_W-1:0] w_pht_nxt;
  logic [GHR_W-1:0] w_ghr_nxt;
  logic             w_unused;

  assign w_unused = ^{i_if_pc[1:0], i_upd_pc[1:0]};

  // Lookup path: purely combinational from registered table state.
  assign w_lk_idx  = i_if_pc[IDX_W+1:2];
  assign w_lk_tag  = i_if_pc[31:IDX_W+2];
  assign w_lk_pidx = (MODE == 2) ? (w_lk_idx ^ IDX_W'(r_ghr)) : w_lk_idx;
  assign w_hit     = r_vld[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_dir     = r_pht[w_lk_pidx][CNT_W-1];

  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = '0;
    if (w_hit) begin
      o_pred_target = r_tgt[w_lk_idx];
      if (MODE == 0) o_pred_taken = r_jmp[w_lk_idx];
      else           o_pred_taken = r_jmp[w_lk_idx] || w_dir;
    end
  end

  // Update path; the PHT index is formed from the pre-update history.
  assign w_up_idx  = i_upd_pc[IDX_W+1:2];
  assign w_up_tag  = i_upd_pc[31:IDX_W+2];
  assign w_up_pidx = (MODE == 2) ? (w_up_idx ^ IDX_W'(r_ghr)) : w_up_idx;
  assign w_upd_eff = i_upd_vld && (i_upd_is_br || i_upd_is_jmp);
  assign w_pht_cur = r_pht[w_up_pidx];
  assign w_ghr_nxt = GHR_W'({r_ghr, i_upd_taken});

  always_comb begin
    w_pht_nxt = w_pht_cur;
    if (i_upd_taken && (w_pht_cur != '1))       w_pht_nxt = w_pht_cur + 1'b1;
    else if (!i_upd_taken && (w_pht_cur != '0)) w_pht_nxt = w_pht_cur - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_jmp[i] <= 1'b0;
        r_pht[i] <= PHT_INIT;
      end
      r_ghr <= '0;
    end else if (i_flush_tbl) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_vld[i] <= 1'b0;
        r_pht[i] <= PHT_INIT;
      end
      r_ghr <= '0;
    end else if (w_upd_eff) begin
      if (i_upd_taken) begin
        r_vld[w_up_idx] <= 1'b1;
        r_tag[w_up_idx] <= w_up_tag;
        r_tgt[w_up_idx] <= i_upd_target;
        r_jmp[w_up_idx] <= i_upd_is_jmp;
      end
      if (i_upd_is_br) begin
        r_pht[w_up_pidx] <= w_pht_nxt;
        r_ghr            <= w_ghr_nxt;
      end
    end
  end

  // A flush drops any simultaneous update, so it is not counted either.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else if (!i_flush_tbl && w_upd_eff) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (i_upd_mispred) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mis_cnt;

endmodule

// File: tb/tb_bpu_btb.sv
// Self-checking bench for bpu_btb: static, bimodal and gshare instances share
// stimulus and are compared against a table-level reference model.
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_pc;
  logic        upd_vld, upd_br, upd_jmp, upd_tk, upd_mp, flush;
  logic [31:0] upd_pc, upd_tgt;
  logic        pt [3];
  logic [31:0] tg [3];
  logic [31:0] bc [3];
  logic [31:0] mc [3];

  int unsigned n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bpu_btb #(.ENTRIES(16), .CNT_W(2), .MODE(0)) u_static (
    .i_clk(clk), .i_rstn(rstn), .i_if_pc(if_pc),
    .o_pred_taken(pt[0]), .o_pred_target(tg[0]),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_is_br(upd_br),
    .i_upd_is_jmp(upd_jmp), .i_upd_taken(upd_tk), .i_upd_target(upd_tgt),
    .i_upd_mispred(upd_mp), .i_flush_tbl(flush),
    .o_br_cnt(bc[0]), .o_mispred_cnt(mc[0]));

  bpu_btb #(.ENTRIES(16), .CNT_W(2), .MODE(1)) u_bimodal (
    .i_clk(clk), .i_rstn(rstn), .i_if_pc(if_pc),
    .o_pred_taken(pt[1]), .o_pred_target(tg[1]),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_is_br(upd_br),
    .i_upd_is_jmp(upd_jmp), .i_upd_taken(upd_tk), .i_upd_target(upd_tgt),
    .i_upd_mispred(upd_mp), .i_flush_tbl(flush),
    .o_br_cnt(bc[1]), .o_mispred_cnt(mc[1]));

  bpu_btb #(.ENTRIES(16), .CNT_W(2), .MODE(2), .GHR_W(4)) u_gshare (
    .i_clk(clk), .i_rstn(rstn), .i_if_pc(if_pc),
    .o_pred_taken(pt[2]), .o_pred_target(tg[2]),
    .i_upd_vld(upd_vld), .i_upd_pc(upd_pc), .i_upd_is_br(upd_br),
    .i_upd_is_jmp(upd_jmp), .i_upd_taken(upd_tk), .i_upd_target(upd_tgt),
    .i_upd_mispred(upd_mp), .i_flush_tbl(flush),
    .o_br_cnt(bc[2]), .o_mispred_cnt(mc[2]));

  // Reference model: per-mode tables, shared 4-bit history and counters.
  bit          m_vld [3][16];
  int unsigned m_tag [3][16];
  int unsigned m_tgt [3][16];
  bit          m_jmp [3][16];
  int          m_pht [3][16];
  int unsigned m_ghr;
  int unsigned m_br, m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int bidx(input int unsigned pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic int pidx(input int m, input int unsigned pc);
    return (m == 2) ? (bidx(pc) ^ int'(m_ghr)) : bidx(pc);
  endfunction

  function automatic bit m_hit(input int m, input int unsigned pc);
    return m_vld[m][bidx(pc)] && (m_tag[m][bidx(pc)] == pc / 64);
  endfunction

  function automatic bit m_pred(input int m, input int unsigned pc);
    if (!m_hit(m, pc)) return 1'b0;
    if (m_jmp[m][bidx(pc)]) return 1'b1;
    return (m != 0) && (m_pht[m][pidx(m, pc)] >= 2);
  endfunction

  function automatic int unsigned m_target(input int m, input int unsigned pc);
    return m_hit(m, pc) ? m_tgt[m][bidx(pc)] : 0;
  endfunction

  task automatic m_clear_tables();
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 16; i++) begin
        m_vld[m][i] = 1'b0;
        m_pht[m][i] = 1;
      end
    m_ghr = 0;
  endtask

  task automatic m_reset();
    m_clear_tables();
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic m_apply();
    int pi;
    if (flush) begin
      m_clear_tables();
    end else if (upd_vld && (upd_br || upd_jmp)) begin
      for (int m = 0; m < 3; m++) begin
        pi = pidx(m, upd_pc);
        if (upd_tk) begin
          m_vld[m][bidx(upd_pc)] = 1'b1;
          m_tag[m][bidx(upd_pc)] = upd_pc / 64;
          m_tgt[m][bidx(upd_pc)] = upd_tgt;
          m_jmp[m][bidx(upd_pc)] = upd_jmp;
        end
        if (upd_br) begin
          if (upd_tk && m_pht[m][pi] < 3) m_pht[m][pi]++;
          if (!upd_tk && m_pht[m][pi] > 0) m_pht[m][pi]--;
        end
      end
      if (upd_br) m_ghr = ((m_ghr * 2) + (upd_tk ? 1 : 0)) % 16;
      m_br++;
      if (upd_mp) m_mis++;
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("m%0d_taken pc=%08h", m, if_pc), {31'd0, pt[m]}, {31'd0, m_pred(m, if_pc)});
      chk($sformatf("m%0d_target pc=%08h", m, if_pc), tg[m], m_target(m, if_pc));
      chk($sformatf("m%0d_br_cnt", m), bc[m], m_br);
      chk($sformatf("m%0d_mis_cnt", m), mc[m], m_mis);
    end
  endtask

  task automatic drive(input logic uv, input logic [31:0] upc, input logic br, input logic jmp,
                       input logic tk, input logic [31:0] tgt, input logic mp, input logic fl,
                       input logic [31:0] lpc);
    upd_vld = uv; upd_pc = upc; upd_br = br; upd_jmp = jmp;
    upd_tk = tk; upd_tgt = tgt; upd_mp = mp; flush = fl; if_pc = lpc;
  endtask

  // One clock: drive, check lookups against pre-edge state, then advance the model.
  task automatic cyc(input logic uv, input logic [31:0] upc, input logic br, input logic jmp,
                     input logic tk, input logic [31:0] tgt, input logic mp, input logic fl,
                     input logic [31:0] lpc);
    @(negedge clk);
    drive(uv, upc, br, jmp, tk, tgt, mp, fl, lpc);
    #1 check_all();
    @(posedge clk);
    #1 m_apply();
  endtask

  task automatic look(input logic [31:0] lpc);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, lpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    rstn = 1'b0;
    #1 m_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit br, jmp;
    int unsigned kind;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    look(32'h40);
    chk("init_taken", {31'd0, pt[1]}, 32'd0);

    // Allocate, then same-index alias with a different tag misses.
    cyc(1, 32'h40, 1, 0, 1, 32'h100, 0, 0, 32'h40);
    look(32'h40);
    chk("s2_taken", {31'd0, pt[1]}, 32'd1);
    chk("s2_target", tg[1], 32'h100);
    look(32'h80);
    chk("s2_alias", {31'd0, pt[1]}, 32'd0);

    repeat (3) cyc(1, 32'h40, 1, 0, 1, 32'h100, 0, 0, 32'h40);
    cyc(1, 32'h40, 1, 0, 0, 32'h0, 1, 0, 32'h40);
    look(32'h40);
    chk("s3_weak_taken", {31'd0, pt[1]}, 32'd1);
    cyc(1, 32'h40, 1, 0, 0, 32'h0, 1, 0, 32'h40);
    look(32'h40);
    chk("s3_not_taken", {31'd0, pt[1]}, 32'd0);
    chk("s3_entry_kept", tg[1], 32'h100);

    // Asynchronous reset mid-update.
    @(negedge clk);
    drive(1, 32'h48, 1, 0, 1, 32'h300, 1, 0, 32'h40);
    #2 rstn = 1'b0;
    #1 m_reset();
    check_all();
    chk("rst_taken", {31'd0, pt[1]}, 32'd0);
    chk("rst_target", tg[1], 32'd0);
    chk("rst_br_cnt", bc[1], 32'd0);
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    rstn = 1'b1;
    #1 check_all();
    chk("rst_rel_mis", mc[1], 32'd0);

    // Static mode: jumps predicted, branches never.
    cyc(1, 32'h10, 0, 1, 1, 32'h200, 0, 0, 32'h10);
    look(32'h10);
    chk("s4_jmp_taken", {31'd0, pt[0]}, 32'd1);
    chk("s4_jmp_target", tg[0], 32'h200);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h20, 1, 0, 1, 32'h300, 0, 0, 32'h20);
      look(32'h20);
      chk("s4_static_br", {31'd0, pt[0]}, 32'd0);
    end

    // Gshare history steers the lookup to an untrained counter.
    do_reset();
    cyc(1, 32'h40, 1, 0, 1, 32'h100, 0, 0, 32'h40);
    cyc(1, 32'h40, 1, 0, 1, 32'h100, 0, 0, 32'h40);
    look(32'h40);
    chk("s5_gshare", {31'd0, pt[2]}, 32'd0);
    chk("s5_bimodal", {31'd0, pt[1]}, 32'd1);

    // Perf counters and flush priority.
    do_reset();
    cyc(1, 32'h40, 1, 0, 1, 32'h100, 1, 0, 32'h0);
    cyc(1, 32'h44, 0, 1, 1, 32'h180, 0, 0, 32'h0);
    cyc(1, 32'h4c, 0, 0, 1, 32'h1c0, 1, 0, 32'h0);
    cyc(1, 32'h50, 1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 32'h54, 1, 0, 1, 32'h1f0, 1, 0, 32'h0);
    cyc(1, 32'h58, 0, 1, 1, 32'h220, 0, 0, 32'h44);
    look(32'h44);
    chk("s6_br_cnt", bc[1], 32'd5);
    chk("s6_mis_cnt", mc[1], 32'd2);
    chk("s6_pre_flush_hit", {31'd0, pt[1]}, 32'd1);
    cyc(1, 32'h60, 1, 0, 1, 32'h240, 1, 1, 32'h44);
    look(32'h44);
    chk("s6_flush_taken", {31'd0, pt[1]}, 32'd0);
    chk("s6_flush_br_cnt", bc[1], 32'd5);
    chk("s6_flush_mis_cnt", mc[1], 32'd2);
    look(32'h60);
    chk("s6_dropped_upd", {31'd0, pt[0]}, 32'd0);

    // Randomized traffic with aliasing PCs.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 3);
      br   = (kind == 1) || (kind == 3);
      jmp  = (kind == 2);
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 127) * 4) | $urandom_range(0, 3),
          br, jmp, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1,
          $urandom_range(0, 40) == 0, ($urandom_range(0, 127) * 4) | $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
